// File: rtl/cci_mpf_shim_vtp_svc_arb_if.sv
// Bundles the client-side and service-side lookup channels of the shared VTP
// translation service arbiter. The arbiter uses the slave view; the environment uses the master view.
interface cci_mpf_shim_vtp_svc_arb_if #(
   parameter int NUM_CLIENTS = 4,
   parameter int VA_W        = 36,
   parameter int PA_W        = 36,
   parameter int TAG_W       = 4
);
   logic [NUM_CLIENTS-1:0]       c_lookupEn;
   logic [NUM_CLIENTS*VA_W-1:0]  c_pageVA;
   logic [NUM_CLIENTS*TAG_W-1:0] c_tag;
   logic [NUM_CLIENTS-1:0]       c_lookupRdy;
   logic [NUM_CLIENTS-1:0]       c_rspValid;
   logic [PA_W-1:0]              c_rspPagePA;
   logic [TAG_W-1:0]             c_rspTag;
   logic                         c_rspIsBigPage;

   logic                         s_lookupEn;
   logic [VA_W-1:0]              s_pageVA;
   logic [TAG_W-1:0]             s_tag;
   logic                         s_lookupRdy;
   logic                         s_rspValid;
   logic [PA_W-1:0]              s_rspPagePA;
   logic [TAG_W-1:0]             s_rspTag;
   logic                         s_rspIsBigPage;

   modport slave (
      input  c_lookupEn, c_pageVA, c_tag,
      output c_lookupRdy, c_rspValid, c_rspPagePA, c_rspTag, c_rspIsBigPage,
      output s_lookupEn, s_pageVA, s_tag,
      input  s_lookupRdy, s_rspValid, s_rspPagePA, s_rspTag, s_rspIsBigPage
   );

   modport master (
      output c_lookupEn, c_pageVA, c_tag,
      input  c_lookupRdy, c_rspValid, c_rspPagePA, c_rspTag, c_rspIsBigPage,
      input  s_lookupEn, s_pageVA, s_tag,
      output s_lookupRdy, s_rspValid, s_rspPagePA, s_rspTag, s_rspIsBigPage
   );
endinterface

// File: rtl/cci_mpf_shim_vtp_svc_arb.sv
// Shares one VTP translation service among several pipeline shims: round-robin
// request arbitration, client tag -> global tag remapping, response routing.
module cci_mpf_shim_vtp_svc_arb #(
   parameter int NUM_CLIENTS = 4,
   parameter int N_TAGS      = 16,
   parameter int VA_W        = 36,
   parameter int PA_W        = 36,
   parameter int TAG_W       = $clog2(N_TAGS)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   cci_mpf_shim_vtp_svc_arb_if.slave   bus,
   output logic [TAG_W:0]              tagsBusy,
   output logic                        errBadRsp
);
   localparam int CLI_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   logic [N_TAGS-1:0] freeMask;
   logic [N_TAGS-1:0] freeNext;
   logic [CLI_W-1:0]  ownerCli [N_TAGS];
   logic [TAG_W-1:0]  ownerTag [N_TAGS];
   logic [CLI_W-1:0]  rrPtr;

   logic              canIssue;
   logic              grant;
   logic              rspHit;
   logic [TAG_W-1:0]  selTag;
   logic [CLI_W-1:0]  winner;

   // Lowest-numbered free tag; the descending scan leaves the smallest index last.
   always_comb begin
      selTag = '0;
      for (int t = N_TAGS - 1; t >= 0; t--)
         if (freeMask[t]) selTag = TAG_W'(t);
   end

   // First requester at or above rrPtr, wrapping; scanned in reverse so the closest wins.
   always_comb begin
      int idx;
      idx    = 0;
      winner = rrPtr;
      for (int j = NUM_CLIENTS - 1; j >= 0; j--) begin
         idx = int'(rrPtr) + j;
         if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
         if (bus.c_lookupEn[CLI_W'(idx)]) winner = CLI_W'(idx);
      end
   end

   assign canIssue        = bus.s_lookupRdy & (|freeMask);
   assign grant           = canIssue & (|bus.c_lookupEn);
   assign rspHit          = bus.s_rspValid & ~freeMask[bus.s_rspTag];

   assign bus.c_lookupRdy = grant ? (NUM_CLIENTS'(1) << winner) : '0;
   assign bus.s_lookupEn  = grant;
   assign bus.s_pageVA    = bus.c_pageVA[winner*VA_W +: VA_W];
   assign bus.s_tag       = selTag;

   // A granted tag is free and a hit response tag is busy, so the two never collide.
   always_comb begin
      freeNext = freeMask;
      if (grant)  freeNext[selTag]       = 1'b0;
      if (rspHit) freeNext[bus.s_rspTag] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         freeMask           <= '1;
         rrPtr              <= '0;
         tagsBusy           <= '0;
         errBadRsp          <= 1'b0;
         bus.c_rspValid     <= '0;
         bus.c_rspPagePA    <= '0;
         bus.c_rspTag       <= '0;
         bus.c_rspIsBigPage <= 1'b0;
      end else begin
         freeMask <= freeNext;
         tagsBusy <= tagsBusy + (TAG_W+1)'(grant) - (TAG_W+1)'(rspHit);
         if (grant)
            rrPtr <= (int'(winner) == NUM_CLIENTS - 1) ? '0 : winner + CLI_W'(1);
         if (bus.s_rspValid && !rspHit)
            errBadRsp <= 1'b1;
         bus.c_rspValid <= rspHit ? (NUM_CLIENTS'(1) << ownerCli[bus.s_rspTag]) : '0;
         if (rspHit) begin
            bus.c_rspTag       <= ownerTag[bus.s_rspTag];
            bus.c_rspPagePA    <= bus.s_rspPagePA;
            bus.c_rspIsBigPage <= bus.s_rspIsBigPage;
         end
      end
   end

   // NOTE: the owner table is not reset; a free bit guards every entry, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (grant) begin
         ownerCli[selTag] <= winner;
         ownerTag[selTag] <= bus.c_tag[winner*TAG_W +: TAG_W];
      end
   end

   a_rsp_tag_busy: assert property (@(posedge clk) disable iff (!reset_n)
      bus.s_rspValid |-> !freeMask[bus.s_rspTag])
      else $warning("vtp svc arb: response for unallocated tag %0d", bus.s_rspTag);
endmodule
